os_tile_fault_sequencer: RTL and testbench



---
 rtl/os_tile_fault_sequencer_if.sv | 38 +++
 rtl/os_tile_fault_sequencer.sv | 179 +++++++++++++++++
 tb/tb_os_tile_fault_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/os_tile_fault_sequencer_if.sv
// rtl/os_tile_fault_sequencer_if.sv - host/array-side bundle of the OS tile fault sequencer
interface os_tile_fault_sequencer_if #(
  parameter int D_W   = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_k;
  logic [CNT_W-1:0] cfg_tiles;
  logic             cfg_fault_en;
  logic [D_W-1:0]   cfg_fault_mask;
  logic [CNT_W-1:0] cfg_fault_cycle;
  logic [CNT_W-1:0] cfg_fault_len;
  logic             busy;
  logic             done;
  logic             feed_valid;
  logic             init_r;
  logic             data_rsrv;
  logic [D_W-1:0]   fault_mask;
  logic             fault_active;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] tile_idx;
  logic [CNT_W-1:0] fault_cnt;

  modport master (
    output start, abort, cfg_k, cfg_tiles, cfg_fault_en, cfg_fault_mask,
           cfg_fault_cycle, cfg_fault_len,
    input  busy, done, feed_valid, init_r, data_rsrv, fault_mask, fault_active,
           cyc, tile_idx, fault_cnt
  );

  modport slave (
    input  start, abort, cfg_k, cfg_tiles, cfg_fault_en, cfg_fault_mask,
           cfg_fault_cycle, cfg_fault_len,
    output busy, done, feed_valid, init_r, data_rsrv, fault_mask, fault_active,
           cyc, tile_idx, fault_cnt
  );
endinterface

// File: rtl/os_tile_fault_sequencer.sv
// rtl/os_tile_fault_sequencer.sv - tile feed/init/drain sequencer with one fault window per run
// Optional: FAULT_STATS_EN enables the fault_cnt counter and window open/close messages.
module os_tile_fault_sequencer #(
  parameter int D_W   = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  os_tile_fault_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FEED, INIT, DRAIN, DONE} state_t;

  localparam logic [CNT_W:0] FEED_SKEW  = (CNT_W+1)'(ROWS + COLS - 3);
  localparam logic [CNT_W:0] DRAIN_LAST = (CNT_W+1)'(ROWS - 1);

  state_t           state;
  logic [CNT_W-1:0] k_q, tiles_q, fcyc_q, flen_q;
  logic             en_q;
  logic [D_W-1:0]   mask_q;
  logic [CNT_W:0]   ph;
  logic             busy_q, done_q, feed_q, init_q, rsrv_q, fa_q;
  logic [D_W-1:0]   fm_q;
  logic [CNT_W-1:0] cyc_q, tile_q;

  // Window test uses a CNT_W+1 bit end so a window reaching past all-ones does not wrap.
  function automatic logic in_window(input logic en, input logic [CNT_W-1:0] fc,
                                     input logic [CNT_W-1:0] fl, input logic [CNT_W-1:0] c);
    logic [CNT_W:0] end_c;
    end_c = {1'b0, fc} + {1'b0, fl};
    return en && (c >= fc) && ((fl == '0) || ({1'b0, c} < end_c));
  endfunction

  logic [CNT_W-1:0] cyc_inc;
  logic [CNT_W:0]   feed_last;
  logic             win_start, win_next, more_tiles;

  assign cyc_inc    = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
  assign feed_last  = {1'b0, k_q} + FEED_SKEW;
  assign win_start  = in_window(bus.cfg_fault_en, bus.cfg_fault_cycle, bus.cfg_fault_len, '0);
  assign win_next   = in_window(en_q, fcyc_q, flen_q, cyc_inc);
  assign more_tiles = ({1'b0, tile_q} + 1'b1) < {1'b0, tiles_q};

  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state  <= IDLE;
      ph     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      feed_q <= 1'b0;
      init_q <= 1'b0;
      rsrv_q <= 1'b0;
      fa_q   <= 1'b0;
      fm_q   <= '0;
      cyc_q  <= '0;
      tile_q <= '0;
      if (rst) begin
        k_q     <= '0;
        tiles_q <= '0;
        fcyc_q  <= '0;
        flen_q  <= '0;
        en_q    <= 1'b0;
        mask_q  <= '0;
      end
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          k_q     <= bus.cfg_k;
          tiles_q <= bus.cfg_tiles;
          fcyc_q  <= bus.cfg_fault_cycle;
          flen_q  <= bus.cfg_fault_len;
          en_q    <= bus.cfg_fault_en;
          mask_q  <= bus.cfg_fault_mask;
          busy_q  <= 1'b1;
          cyc_q   <= '0;
          tile_q  <= '0;
          ph      <= '0;
          if (bus.cfg_k == '0 || bus.cfg_tiles == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state  <= FEED;
            feed_q <= 1'b1;
            fa_q   <= win_start;
            fm_q   <= win_start ? bus.cfg_fault_mask : '0;
          end
        end
        FEED: begin
          cyc_q <= cyc_inc;
          fa_q  <= win_next;
          fm_q  <= win_next ? mask_q : '0;
          if (ph == feed_last) begin
            state  <= INIT;
            ph     <= '0;
            feed_q <= 1'b0;
            init_q <= 1'b1;
          end else begin
            ph     <= ph + 1'b1;
            feed_q <= (ph + 1'b1) < {1'b0, k_q};
          end
        end
        INIT: begin
          state  <= DRAIN;
          cyc_q  <= cyc_inc;
          init_q <= 1'b0;
          rsrv_q <= 1'b1;
          fa_q   <= win_next;
          fm_q   <= win_next ? mask_q : '0;
        end
        DRAIN: begin
          cyc_q <= cyc_inc;
          fa_q  <= win_next;
          fm_q  <= win_next ? mask_q : '0;
          if (ph == DRAIN_LAST) begin
            ph     <= '0;
            rsrv_q <= 1'b0;
            if (more_tiles) begin
              state  <= FEED;
              tile_q <= tile_q + 1'b1;
              feed_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
              fa_q   <= 1'b0;
              fm_q   <= '0;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          cyc_q  <= '0;
          tile_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.feed_valid   = feed_q;
  assign bus.init_r       = init_q;
  assign bus.data_rsrv    = rsrv_q;
  assign bus.fault_active = fa_q;
  assign bus.fault_mask   = fm_q;
  assign bus.cyc          = cyc_q;
  assign bus.tile_idx     = tile_q;

`ifdef FAULT_STATS_EN
  logic [CNT_W-1:0] fcnt_q;
  logic             fa_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      fa_d   <= 1'b0;
    end else begin
      if (state == IDLE && bus.start && !bus.abort)
        fcnt_q <= '0;
      else if (fa_q && !(&fcnt_q))
        fcnt_q <= fcnt_q + 1'b1;
      fa_d <= fa_q;
      if (fa_q && !fa_d)
        $display("fault window open: tile_idx=%0d cyc=%0d mask=%h", tile_q, cyc_q, fm_q);
      if (!fa_q && fa_d)
        $display("fault window close: tile_idx=%0d cyc=%0d mask=%h", tile_q, cyc_q, mask_q);
    end
  end

  assign bus.fault_cnt = fcnt_q;
`else
  assign bus.fault_cnt = '0;
`endif
endmodule

// File: tb/tb_os_tile_fault_sequencer.sv
// tb/tb_os_tile_fault_sequencer.sv - directed and randomized check of os_tile_fault_sequencer
module tb_os_tile_fault_sequencer;
  localparam int D_W = 8, ROWS = 4, COLS = 4, CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  os_tile_fault_sequencer_if #(.D_W(D_W), .CNT_W(CNT_W)) bus ();

  os_tile_fault_sequencer #(.D_W(D_W), .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] observed();
    return {18'b0, bus.busy, bus.done, bus.feed_valid, bus.init_r, bus.data_rsrv,
            bus.fault_active, bus.fault_mask, bus.cyc, bus.tile_idx};
  endfunction

  // Expected outputs at cyc n, derived from tile length and phase offsets within a tile.
  function automatic logic [63:0] model(input int n, input int k, input int tiles, input int en,
                                        input int mask, input int fc, input int fl);
    int L, total, o, t;
    logic in_run, b, d, fv, ir, dr, fa;
    logic [7:0]  fm;
    logic [15:0] cy, ti;
    L      = k + 2*ROWS + COLS - 1;
    total  = (k == 0 || tiles == 0) ? 0 : tiles * L;
    in_run = n < total;
    o      = n % L;
    t      = n / L;
    b      = 1'b1;
    d      = (n == total);
    fv     = in_run && (o < k);
    ir     = in_run && (o == k + ROWS + COLS - 2);
    dr     = in_run && (o > k + ROWS + COLS - 2);
    fa     = (en != 0) && in_run && (n >= fc) && (fl == 0 || longint'(n) < longint'(fc) + longint'(fl));
    fm     = fa ? 8'(mask) : 8'h00;
    cy     = 16'(n);
    ti     = in_run ? 16'(t) : ((total != 0) ? 16'(tiles - 1) : 16'h0);
    return {18'b0, b, d, fv, ir, dr, fa, fm, cy, ti};
  endfunction

  function automatic logic [63:0] exp_fault_cnt(input int n);
`ifdef FAULT_STATS_EN
    return 64'(n);
`else
    return 64'(n & 0);
`endif
  endfunction

  task automatic run(input string tag, input int k, input int tiles, input int en,
                     input int mask, input int fc, input int fl, input int abort_at);
    int total, nfa;
    logic [63:0] e;
    bus.cfg_k           = 16'(k);
    bus.cfg_tiles       = 16'(tiles);
    bus.cfg_fault_en    = (en != 0);
    bus.cfg_fault_mask  = 8'(mask);
    bus.cfg_fault_cycle = 16'(fc);
    bus.cfg_fault_len   = 16'(fl);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total = (k == 0 || tiles == 0) ? 0 : tiles * (k + 2*ROWS + COLS - 1);
    nfa = 0;
    for (int n = 0; n <= total; n++) begin
      e = model(n, k, tiles, en, mask, fc, fl);
      chk($sformatf("%s n=%0d", tag, n), observed(), e);
      if (e[40]) nfa++;
      if (n == abort_at) begin
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk({tag, " after_abort"}, observed(), 64'h0);
        chk({tag, " abort_fault_cnt"}, 64'(bus.fault_cnt), exp_fault_cnt(nfa));
        return;
      end
      // live cfg churn and stray starts must not disturb the latched run
      bus.cfg_k           = 16'($urandom);
      bus.cfg_tiles       = 16'($urandom);
      bus.cfg_fault_en    = 1'($urandom);
      bus.cfg_fault_mask  = 8'($urandom);
      bus.cfg_fault_cycle = 16'($urandom_range(0, 20));
      bus.cfg_fault_len   = 16'($urandom_range(0, 3));
      bus.start           = 1'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, " idle_after_done"}, observed(), 64'h0);
    chk({tag, " fault_cnt"}, 64'(bus.fault_cnt), exp_fault_cnt(nfa));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_k = '0;
    bus.cfg_tiles = '0;
    bus.cfg_fault_en = 1'b0;
    bus.cfg_fault_mask = '0;
    bus.cfg_fault_cycle = '0;
    bus.cfg_fault_len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", observed(), 64'h0);
    chk("reset_fault_cnt", 64'(bus.fault_cnt), 64'h0);

    run("single_tile", 3, 1, 0, 0, 0, 0, -1);
    run("two_tiles", 3, 2, 0, 0, 0, 0, -1);
    run("transient", 3, 1, 1, 8'h80, 5, 2, -1);
    run("permanent", 3, 1, 1, 8'h01, 3, 0, -1);
    run("late_window", 3, 1, 1, 8'hff, 20, 4, -1);
    run("abort", 3, 1, 0, 0, 0, 0, 6);
    run("after_abort_run", 3, 1, 0, 0, 0, 0, -1);
    run("zero_k", 0, 1, 1, 8'h55, 0, 0, -1);
    run("zero_tiles", 3, 0, 1, 8'h55, 0, 0, -1);

    bus.cfg_k = 16'd3;
    bus.cfg_tiles = 16'd1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_beats_start", observed(), 64'h0);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_run", observed(), 64'h0);
    chk("rst_mid_run_fault_cnt", 64'(bus.fault_cnt), 64'h0);

    for (int i = 0; i < 12; i++) begin
      int fl;
      fl = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8));
      run($sformatf("rand%0d", i), int'($urandom_range(1, 6)), int'($urandom_range(1, 3)), 1,
          int'($urandom_range(1, 255)), int'($urandom_range(0, 40)), fl, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
